// File: rtl/axis_frame_scheduler.sv
// Shares one AXI4-Stream master between two frame sources: round-robin grants on frame
// boundaries, one frame start per token period, and TLAST forced at FRAME_LEN beats.
module axis_frame_scheduler #(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN            = 4096,
    parameter int unsigned PERIOD               = 5900
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESET,
    input  logic                            START,

    input  logic                            S0_AXIS_TVALID,
    output logic                            S0_AXIS_TREADY,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] S0_AXIS_TDATA,
    input  logic                            S0_AXIS_TLAST,

    input  logic                            S1_AXIS_TVALID,
    output logic                            S1_AXIS_TREADY,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] S1_AXIS_TDATA,
    input  logic                            S1_AXIS_TLAST,

    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,

    output logic [1:0]                      GRANT,
    output logic                            FRAME_DONE,
    output logic                            OVERRUN
);

    typedef enum logic [1:0] {StIdle, StArb, StXfer} state_e;

    localparam logic [31:0] TimerMax = 32'(PERIOD - 1);
    localparam logic [15:0] BeatMax  = 16'(FRAME_LEN - 1);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        token_q, token_d;
    logic [15:0] beat_q, beat_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_s1_q, last_s1_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic                            tick;
    logic                            in_xfer;
    logic                            sel_s1;
    logic                            src_valid;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] src_data;
    logic                            src_last;
    logic                            handshake;
    logic                            frame_end;
    logic                            any_valid;
    logic                            pick_s1;
    logic                            grant_now;

    assign tick    = START && (timer_q == TimerMax);
    assign in_xfer = (state_q == StXfer);
    assign sel_s1  = grant_q[1];

    // Granted-source pass-through; everything is forced to zero outside a frame.
    always_comb begin
        src_valid = sel_s1 ? S1_AXIS_TVALID : S0_AXIS_TVALID;
        src_data  = sel_s1 ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
        src_last  = sel_s1 ? S1_AXIS_TLAST  : S0_AXIS_TLAST;

        M_AXIS_TVALID  = in_xfer && src_valid;
        M_AXIS_TDATA   = in_xfer ? src_data : '0;
        M_AXIS_TLAST   = in_xfer && (src_last || (beat_q == BeatMax));
        S0_AXIS_TREADY = in_xfer && !sel_s1 && M_AXIS_TREADY;
        S1_AXIS_TREADY = in_xfer && sel_s1 && M_AXIS_TREADY;
    end

    assign M_AXIS_TSTRB = '1;
    assign GRANT        = grant_q;
    assign FRAME_DONE   = done_q;
    assign OVERRUN      = overrun_q;

    assign handshake = M_AXIS_TVALID && M_AXIS_TREADY;
    assign frame_end = handshake && M_AXIS_TLAST;

    // S1 wins only when S0 is idle or S0 was the most recent owner.
    assign any_valid = S0_AXIS_TVALID || S1_AXIS_TVALID;
    assign pick_s1   = S1_AXIS_TVALID && (!S0_AXIS_TVALID || !last_s1_q);
    assign grant_now = (state_q == StArb) && START && token_q && any_valid;

    always_comb begin
        timer_d = 32'd0;
        if (START && !tick) begin
            timer_d = timer_q + 32'd1;
        end
    end

    // A grant consumes the pending token; a tick in the same cycle re-arms it.
    assign token_d   = START && (tick || (token_q && !grant_now));
    assign overrun_d = tick && token_q && !grant_now;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        last_s1_d = last_s1_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (!START) begin
                    state_d = StIdle;
                end else if (grant_now) begin
                    state_d = StXfer;
                    grant_d = pick_s1 ? 2'b10 : 2'b01;
                    beat_d  = 16'd0;
                end
            end
            StXfer: begin
                if (frame_end) begin
                    done_d    = 1'b1;
                    last_s1_d = sel_s1;
                    grant_d   = 2'b00;
                    beat_d    = 16'd0;
                    state_d   = START ? StArb : StIdle;
                end else if (handshake) begin
                    beat_d = beat_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q   <= StIdle;
            timer_q   <= 32'd0;
            token_q   <= 1'b0;
            beat_q    <= 16'd0;
            grant_q   <= 2'b00;
            last_s1_q <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            token_q   <= token_d;
            beat_q    <= beat_d;
            grant_q   <= grant_d;
            last_s1_q <= last_s1_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Directed bench for axis_frame_scheduler: per-source scoreboards fed at stimulus time,
// popped on every master handshake, plus cycle-exact grant/token/overrun checks.
module tb_axis_frame_scheduler;

    localparam int unsigned W   = 8;
    localparam int unsigned FL  = 4;
    localparam int unsigned PER = 20;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         s0_tvalid = 1'b0;
    logic         s0_tready;
    logic [W-1:0] s0_tdata = '0;
    logic         s0_tlast = 1'b0;
    logic         s1_tvalid = 1'b0;
    logic         s1_tready;
    logic [W-1:0] s1_tdata = '0;
    logic         s1_tlast = 1'b0;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [W-1:0] m_tdata;
    logic [W-1:0] m_tstrb;
    logic         m_tlast;
    logic [1:0]   grant;
    logic         frame_done;
    logic         overrun;

    axis_frame_scheduler #(
        .C_M_AXIS_TDATA_WIDTH(W),
        .FRAME_LEN           (FL),
        .PERIOD              (PER)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .START         (start),
        .S0_AXIS_TVALID(s0_tvalid),
        .S0_AXIS_TREADY(s0_tready),
        .S0_AXIS_TDATA (s0_tdata),
        .S0_AXIS_TLAST (s0_tlast),
        .S1_AXIS_TVALID(s1_tvalid),
        .S1_AXIS_TREADY(s1_tready),
        .S1_AXIS_TDATA (s1_tdata),
        .S1_AXIS_TLAST (s1_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TLAST  (m_tlast),
        .GRANT         (grant),
        .FRAME_DONE    (frame_done),
        .OVERRUN       (overrun)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    ovr_cnt = 0;
    int    pos0 = 0;
    int    pos1 = 0;
    bit    ready_toggle = 1'b0;
    logic  s0_take = 1'b0;
    logic  s1_take = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] grant_log[$];
    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t exp0_q[$];
    beat_t exp1_q[$];
    beat_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source n beats, TLAST on the last; expected master TLAST also fires every FL beats.
    task automatic push_frame(input int src, input int n, input int base);
        beat_t b;
        beat_t e;
        for (int i = 0; i < n; i++) begin
            b.data = W'(base + i);
            b.last = (i == n - 1);
            e.data = b.data;
            if (src == 0) begin
                e.last = b.last || (pos0 == int'(FL) - 1);
                pos0   = e.last ? 0 : pos0 + 1;
                src0_q.push_back(b);
                exp0_q.push_back(e);
            end else begin
                e.last = b.last || (pos1 == int'(FL) - 1);
                pos1   = e.last ? 0 : pos1 + 1;
                src1_q.push_back(b);
                exp1_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        ready_toggle = 1'b0;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_mvalid", 32'(m_tvalid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #2;
        src0_q.delete();
        src1_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        pos0 = 0;
        pos1 = 0;
        rst = 1'b0;
    endtask

    // Raise START at cycle 0: token appears at cycle 20, GRANT at cycle 21.
    task automatic start_run(input string tag, input logic [1:0] exp_grant);
        @(posedge clk);
        #1;
        start = 1'b1;
        repeat (21) @(negedge clk);
        check({tag, "_grant_c20"}, 32'(grant), 32'd0);
        @(negedge clk);
        check({tag, "_grant_c21"}, 32'(grant), 32'(exp_grant));
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, 32'(done_cnt >= target), 32'd1);
    endtask

    // Monitor: samples mid-cycle, scores master beats against the granted source.
    always @(negedge clk) begin
        s0_take = s0_tvalid && s0_tready;
        s1_take = s1_tvalid && s1_tready;
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (overrun) ovr_cnt++;
            if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
            if (grant == 2'b00) begin
                check("idle_mvalid", 32'(m_tvalid), 32'd0);
                check("idle_mlast", 32'(m_tlast), 32'd0);
                check("idle_mdata", 32'(m_tdata), 32'd0);
                check("idle_sready", 32'({s1_tready, s0_tready}), 32'd0);
            end else begin
                check("grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 32'd1);
                check("ready_mirror", 32'({s1_tready, s0_tready}),
                      32'(grant[1] ? {m_tready, 1'b0} : {1'b0, m_tready}));
                if (m_tvalid && m_tready) begin
                    checks++;
                    if (grant[1]) begin
                        assert (exp1_q.size() > 0) else begin
                            failures++;
                            $error("FAIL unexpected_beat_s1 observed=%0h expected=none", m_tdata);
                        end
                        if (exp1_q.size() > 0) mon_e = exp1_q.pop_front();
                    end else begin
                        assert (exp0_q.size() > 0) else begin
                            failures++;
                            $error("FAIL unexpected_beat_s0 observed=%0h expected=none", m_tdata);
                        end
                        if (exp0_q.size() > 0) mon_e = exp0_q.pop_front();
                    end
                    check("beat_data", 32'(m_tdata), 32'(mon_e.data));
                    check("beat_last", 32'(m_tlast), 32'(mon_e.last));
                end
            end
        end
        prev_grant = grant;
    end

    // Source models and downstream ready, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (s0_take && src0_q.size() > 0) void'(src0_q.pop_front());
        if (s1_take && src1_q.size() > 0) void'(src1_q.pop_front());
        m_tready  = ready_toggle ? ~m_tready : 1'b1;
        s0_tvalid = src0_q.size() > 0;
        s0_tdata  = (src0_q.size() > 0) ? src0_q[0].data : '0;
        s0_tlast  = (src0_q.size() > 0) ? src0_q[0].last : 1'b0;
        s1_tvalid = src1_q.size() > 0;
        s1_tdata  = (src1_q.size() > 0) ? src1_q[0].data : '0;
        s1_tlast  = (src1_q.size() > 0) ? src1_q[0].last : 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int g0;
        int o0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_mvalid", 32'(m_tvalid), 32'd0);
        check("reset_mlast", 32'(m_tlast), 32'd0);
        check("reset_mdata", 32'(m_tdata), 32'd0);
        check("reset_tstrb", 32'(m_tstrb), 32'h0000_00ff);
        check("reset_sready", 32'({s1_tready, s0_tready}), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single S0 frame of 4 beats.
        d0 = done_cnt;
        push_frame(0, 4, 'h10);
        start_run("t1", 2'b01);
        repeat (4) @(negedge clk);
        check("t1_done_c25", 32'(frame_done), 32'd1);
        check("t1_grant_c25", 32'(grant), 32'd0);
        @(negedge clk);
        check("t1_done_c26", 32'(frame_done), 32'd0);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_exp_empty", 32'(exp0_q.size()), 32'd0);

        // Both sources always valid for three periods.
        do_reset();
        d0 = done_cnt;
        g0 = grant_log.size();
        o0 = ovr_cnt;
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 4, 'h20 + 4 * f);
            push_frame(1, 4, 'h60 + 4 * f);
        end
        start_run("t2", 2'b01);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_grants", 32'(grant_log.size() - g0), 32'd3);
        if (grant_log.size() >= g0 + 3) begin
            check("t2_grant0", 32'(grant_log[g0]), 32'd1);
            check("t2_grant1", 32'(grant_log[g0 + 1]), 32'd2);
            check("t2_grant2", 32'(grant_log[g0 + 2]), 32'd1);
        end
        check("t2_done_count", 32'(done_cnt - d0), 32'd3);
        check("t2_no_overrun", 32'(ovr_cnt - o0), 32'd0);

        // S1 6-beat frame: cut at beat 4, remainder in the next period.
        do_reset();
        push_frame(1, 6, 'h80);
        start_run("t3", 2'b10);
        repeat (4) @(negedge clk);
        check("t3_done_c25", 32'(frame_done), 32'd1);
        repeat (15) @(negedge clk);
        check("t3_grant_c40", 32'(grant), 32'd0);
        @(negedge clk);
        check("t3_grant_c41", 32'(grant), 32'd2);
        repeat (2) @(negedge clk);
        check("t3_done_c43", 32'(frame_done), 32'd1);
        check("t3_exp_empty", 32'(exp1_q.size()), 32'd0);

        // Backpressure: downstream ready toggles every cycle.
        do_reset();
        ready_toggle = 1'b1;
        d0 = done_cnt;
        push_frame(0, 4, 'h40);
        start_run("t4", 2'b01);
        wait_done("t4", d0 + 1, 30);
        ready_toggle = 1'b0;
        check("t4_exp_empty", 32'(exp0_q.size()), 32'd0);

        // No source valid: overrun at the second tick, token kept.
        do_reset();
        o0 = ovr_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_ovr_c39", 32'(overrun), 32'd0);
        @(negedge clk);
        check("t5_ovr_c40", 32'(overrun), 32'd1);
        @(negedge clk);
        check("t5_ovr_c41", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        push_frame(0, 4, 'ha0);
        @(negedge clk);
        check("t5_valid_c45", 32'(s0_tvalid), 32'd1);
        check("t5_grant_c45", 32'(grant), 32'd0);
        @(negedge clk);
        check("t5_grant_c46", 32'(grant), 32'd1);
        wait_done("t5", d0 + 1, 20);
        check("t5_ovr_count", 32'(ovr_cnt - o0), 32'd1);

        // START dropped mid-frame: frame completes, timer restarts from 0.
        do_reset();
        push_frame(0, 4, 'hc0);
        start_run("t6a", 2'b01);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_done_c25", 32'(frame_done), 32'd1);
        check("t6_grant_c25", 32'(grant), 32'd0);
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        push_frame(0, 4, 'hd0);
        start_run("t6b", 2'b01);
        wait_done("t6b", d0 + 1, 20);
        check("t6_exp_empty", 32'(exp0_q.size()), 32'd0);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        push_frame(0, 8, 'he0);
        start_run("t7", 2'b01);
        @(negedge clk);
        check("t7_mvalid_before", 32'(m_tvalid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_mvalid", 32'(m_tvalid), 32'd0);
        check("t7_mlast", 32'(m_tlast), 32'd0);
        check("t7_mdata", 32'(m_tdata), 32'd0);
        check("t7_grant", 32'(grant), 32'd0);
        check("t7_sready", 32'({s1_tready, s0_tready}), 32'd0);
        check("t7_done", 32'(frame_done), 32'd0);
        check("t7_tstrb", 32'(m_tstrb), 32'h0000_00ff);
        start = 1'b0;
        @(posedge clk);
        #2;
        src0_q.delete();
        exp0_q.delete();
        pos0 = 0;
        @(negedge clk);
        check("t7_done_in_reset", 32'(frame_done), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_grant_after", 32'(grant), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
